// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and types for the RV32I decode stage.
//   - alu_op codes (0..19) consumed by the execute-stage ALU
//   - major opcodes and funct7 values recognised by the decoder
//   - dec_t: the bundle of decoded fields carried by the output register
package rv_pkg;

  localparam logic [5:0] ALU_ADD   = 6'd0;
  localparam logic [5:0] ALU_SUB   = 6'd1;
  localparam logic [5:0] ALU_XOR   = 6'd2;
  localparam logic [5:0] ALU_OR    = 6'd3;
  localparam logic [5:0] ALU_AND   = 6'd4;
  localparam logic [5:0] ALU_SLL   = 6'd5;
  localparam logic [5:0] ALU_SRL   = 6'd6;
  localparam logic [5:0] ALU_SRA   = 6'd7;
  localparam logic [5:0] ALU_SLT   = 6'd8;
  localparam logic [5:0] ALU_SLTU  = 6'd9;
  localparam logic [5:0] ALU_ADDI  = 6'd10;
  localparam logic [5:0] ALU_XORI  = 6'd11;
  localparam logic [5:0] ALU_ORI   = 6'd12;
  localparam logic [5:0] ALU_ANDI  = 6'd13;
  localparam logic [5:0] ALU_SLLI  = 6'd14;
  localparam logic [5:0] ALU_SRLI  = 6'd15;
  localparam logic [5:0] ALU_SRAI  = 6'd16;
  localparam logic [5:0] ALU_SLTI  = 6'd17;
  localparam logic [5:0] ALU_SLTIU = 6'd18;
  localparam logic [5:0] ALU_AUIPC = 6'd19;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [5:0]  alu_op;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic        src2_imm;
    logic        reg_write;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/instr_decode_if.sv
// instr_decode_if: handshake and decoded-field bundle of the decode stage.
//   master: upstream fetch + downstream execute side (drives in_*, flush, out_ready)
//   slave : the decode stage (drives in_ready, out_valid and all decoded fields)
interface instr_decode_if #(
  parameter int unsigned PC_W = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      alu_op;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic [31:0]     imm;
  logic            src2_imm;
  logic            reg_write;
  logic            illegal;
  logic [PC_W-1:0] pc_out;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, alu_op, rs1_addr, rs2_addr, rd_addr,
           imm, src2_imm, reg_write, illegal, pc_out
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, alu_op, rs1_addr, rs2_addr, rd_addr,
           imm, src2_imm, reg_write, illegal, pc_out
  );
endinterface

// File: rtl/instr_decode_comb.sv
// instr_decode_comb: purely combinational RV32I decode (R-type, I-type ALU,
// LUI, AUIPC) of one instruction word into the dec_t field bundle.
//   i_instr : raw 32-bit instruction
//   o_dec   : decoded fields; unsupported/malformed words give illegal=1
//             with every other field zero
module instr_decode_comb
  import rv_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_alt;
  logic       w_r_legal;
  logic       w_i_legal;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_alt    = (w_f7 == F7_ALT);

  // The alternate funct7 only exists for SUB and SRA.
  assign w_r_legal = (w_f7 == F7_BASE) ||
                     (w_alt && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));

  // Shift-immediates reuse instr[31:25] as funct7; other I-ops carry imm there.
  assign w_i_legal = (w_f3 == 3'b001) ? (w_f7 == F7_BASE) :
                     (w_f3 == 3'b101) ? ((w_f7 == F7_BASE) || w_alt) :
                                        1'b1;

  always_comb begin
    o_dec         = '0;
    o_dec.illegal = 1'b1;
    case (w_opcode)
      OP_R: begin
        if (w_r_legal) begin
          o_dec.illegal   = 1'b0;
          o_dec.reg_write = 1'b1;
          o_dec.rs1_addr  = i_instr[19:15];
          o_dec.rs2_addr  = i_instr[24:20];
          o_dec.rd_addr   = i_instr[11:7];
          case (w_f3)
            3'b000:  o_dec.alu_op = w_alt ? ALU_SUB : ALU_ADD;
            3'b001:  o_dec.alu_op = ALU_SLL;
            3'b010:  o_dec.alu_op = ALU_SLT;
            3'b011:  o_dec.alu_op = ALU_SLTU;
            3'b100:  o_dec.alu_op = ALU_XOR;
            3'b101:  o_dec.alu_op = w_alt ? ALU_SRA : ALU_SRL;
            3'b110:  o_dec.alu_op = ALU_OR;
            default: o_dec.alu_op = ALU_AND;
          endcase
        end
      end
      OP_IMM: begin
        if (w_i_legal) begin
          o_dec.illegal   = 1'b0;
          o_dec.reg_write = 1'b1;
          o_dec.src2_imm  = 1'b1;
          o_dec.rs1_addr  = i_instr[19:15];
          o_dec.rd_addr   = i_instr[11:7];
          o_dec.imm       = {{20{i_instr[31]}}, i_instr[31:20]};
          case (w_f3)
            3'b000:  o_dec.alu_op = ALU_ADDI;
            3'b001:  begin
              o_dec.alu_op = ALU_SLLI;
              o_dec.imm    = {27'd0, i_instr[24:20]};
            end
            3'b010:  o_dec.alu_op = ALU_SLTI;
            3'b011:  o_dec.alu_op = ALU_SLTIU;
            3'b100:  o_dec.alu_op = ALU_XORI;
            3'b101:  begin
              o_dec.alu_op = i_instr[30] ? ALU_SRAI : ALU_SRLI;
              o_dec.imm    = {27'd0, i_instr[24:20]};
            end
            3'b110:  o_dec.alu_op = ALU_ORI;
            default: o_dec.alu_op = ALU_ANDI;
          endcase
        end
      end
      // LUI is executed as x0 + upper-immediate on the ADDI path.
      OP_LUI: begin
        o_dec.illegal   = 1'b0;
        o_dec.reg_write = 1'b1;
        o_dec.src2_imm  = 1'b1;
        o_dec.alu_op    = ALU_ADDI;
        o_dec.rd_addr   = i_instr[11:7];
        o_dec.imm       = {i_instr[31:12], 12'd0};
      end
      // AUIPC passes the raw 20-bit field; the ALU does the <<12 and adds pc.
      OP_AUIPC: begin
        o_dec.illegal   = 1'b0;
        o_dec.reg_write = 1'b1;
        o_dec.src2_imm  = 1'b1;
        o_dec.alu_op    = ALU_AUIPC;
        o_dec.rd_addr   = i_instr[11:7];
        o_dec.imm       = {12'd0, i_instr[31:12]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_decode.sv
// instr_decode: RV32I decode stage with a single registered output entry.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   io    : instr_decode_if.slave -- valid/ready input (in_*), flush,
//           valid/ready output and the decoded ALU control fields
module instr_decode
  import rv_pkg::*;
#(
  parameter int unsigned PC_W = 6
) (
  input  logic           clock,
  input  logic           reset,
  instr_decode_if.slave  io
);

  logic            r_valid;
  dec_t            r_dec;
  logic [PC_W-1:0] r_pc;
  dec_t            w_dec;
  logic            w_take;

  instr_decode_comb u_comb (
    .i_instr (io.in_instr),
    .o_dec   (w_dec)
  );

  assign io.in_ready = !r_valid || io.out_ready;
  // Flush wins: an input presented in the flush cycle is never captured.
  assign w_take      = io.in_valid && io.in_ready && !io.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_pc    <= '0;
    end else if (io.flush) begin
      r_valid <= 1'b0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_dec   <= w_dec;
      r_pc    <= io.in_pc;
    end else if (io.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign io.out_valid = r_valid;
  assign io.alu_op    = r_dec.alu_op;
  assign io.rs1_addr  = r_dec.rs1_addr;
  assign io.rs2_addr  = r_dec.rs2_addr;
  assign io.rd_addr   = r_dec.rd_addr;
  assign io.imm       = r_dec.imm;
  assign io.src2_imm  = r_dec.src2_imm;
  assign io.reg_write = r_dec.reg_write;
  assign io.illegal   = r_dec.illegal;
  assign io.pc_out    = r_pc;

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed scenarios plus a randomized scoreboard run for
// the instr_decode stage.
module tb_instr_decode;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_decode_if #(.PC_W(6)) bus ();

  instr_decode #(.PC_W(6)) dut (
    .clock (clk),
    .reset (rst_n),
    .io    (bus)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        s2;
    logic        rw;
    logic        ill;
    logic [5:0]  pc;
  } exp_t;

  // Reference decode built from mnemonic tables indexed by funct3.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [5:0] pc);
    logic [5:0] r_tab [8] = '{6'd0, 6'd5, 6'd8, 6'd9, 6'd2, 6'd6, 6'd3, 6'd4};
    logic [5:0] i_tab [8] = '{6'd10, 6'd14, 6'd17, 6'd18, 6'd11, 6'd15, 6'd12, 6'd13};
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    int         simm;
    exp_t e;
    e.op = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.imm = '0;
    e.s2 = 1'b0; e.rw = 1'b0; e.ill = 1'b1; e.pc = pc;
    if (opc == 7'h33 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) begin
      e.ill = 1'b0; e.rw = 1'b1;
      e.op  = r_tab[f3] + {5'd0, f7 == 7'h20};
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    end else if (opc == 7'h13 && !(f3 == 3'd1 && f7 != 7'h00) &&
                 !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
      e.ill = 1'b0; e.rw = 1'b1; e.s2 = 1'b1;
      e.op  = i_tab[f3] + {5'd0, (f3 == 3'd5) && ins[30]};
      e.rs1 = ins[19:15]; e.rd = ins[11:7];
      simm  = $signed(ins[31:20]);
      e.imm = (f3 == 3'd1 || f3 == 3'd5) ? (ins >> 20) % 32 : simm;
    end else if (opc == 7'h37) begin
      e.ill = 1'b0; e.rw = 1'b1; e.s2 = 1'b1; e.op = 6'd10;
      e.rd  = ins[11:7]; e.imm = ins & 32'hFFFF_F000;
    end else if (opc == 7'h17) begin
      e.ill = 1'b0; e.rw = 1'b1; e.s2 = 1'b1; e.op = 6'd19;
      e.rd  = ins[11:7]; e.imm = ins >> 12;
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [5:0] pc,
                       input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_hold_valid got=%0b exp=0", bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready);
    end
    checks++;
    if ({bus.alu_op, bus.imm, bus.pc_out, bus.reg_write, bus.illegal} !== '0) begin
      failures++; $display("FAIL reset_data got alu_op=%0d imm=%0h pc=%0h exp all 0",
                           bus.alu_op, bus.imm, bus.pc_out);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h0020_81B3, 6'h10, 1'b1, 1'b0);
    drive(1'b1, 32'h4020_81B3, 6'h11, 1'b1, 1'b0);
    checks++;
    if ({bus.out_valid, bus.alu_op, bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.src2_imm} !==
        {1'b1, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0}) begin
      failures++; $display("FAIL b2b_add got v=%0b op=%0d rs1=%0d rs2=%0d rd=%0d s2=%0b exp v=1 op=0 rs1=1 rs2=2 rd=3 s2=0",
                           bus.out_valid, bus.alu_op, bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.src2_imm);
    end
    drive(1'b0, 32'h0, 6'h0, 1'b1, 1'b0);
    checks++;
    if ({bus.out_valid, bus.alu_op, bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.src2_imm} !==
        {1'b1, 6'd1, 5'd1, 5'd2, 5'd3, 1'b0}) begin
      failures++; $display("FAIL b2b_sub got v=%0b op=%0d rs1=%0d rs2=%0d rd=%0d s2=%0b exp v=1 op=1 rs1=1 rs2=2 rd=3 s2=0",
                           bus.out_valid, bus.alu_op, bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.src2_imm);
    end
    drive(1'b0, 32'h0, 6'h0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain got=%0b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ins  [5] = '{32'hFFF0_0093, 32'h4033_5293, 32'h1234_5097, 32'hABCD_E137, 32'h0};
    logic [5:0]  pcs  [5] = '{6'h01, 6'h02, 6'h2A, 6'h03, 6'h04};
    logic [5:0]  eop  [5] = '{6'd10, 6'd16, 6'd19, 6'd10, 6'd0};
    logic [31:0] eimm [5] = '{32'hFFFF_FFFF, 32'd3, 32'h0001_2345, 32'hABCD_E000, 32'h0};
    logic [4:0]  ers1 [5] = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd0};
    logic [4:0]  erd  [5] = '{5'd1, 5'd5, 5'd1, 5'd2, 5'd0};
    logic        es2  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        eill [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ins[i], pcs[i], 1'b1, 1'b0);
      drive(1'b0, 32'h0, 6'h0, 1'b1, 1'b0);
      checks++;
      if ({bus.out_valid, bus.alu_op, bus.imm, bus.src2_imm, bus.illegal, bus.reg_write, bus.pc_out} !==
          {1'b1, eop[i], eimm[i], es2[i], eill[i], !eill[i], pcs[i]}) begin
        failures++; $display("FAIL dir_%0h got v=%0b op=%0d imm=%0h s2=%0b ill=%0b rw=%0b pc=%0h exp op=%0d imm=%0h s2=%0b ill=%0b pc=%0h",
                             ins[i], bus.out_valid, bus.alu_op, bus.imm, bus.src2_imm, bus.illegal,
                             bus.reg_write, bus.pc_out, eop[i], eimm[i], es2[i], eill[i], pcs[i]);
      end
      if (!eill[i]) begin
        checks++;
        if ({bus.rs1_addr, bus.rd_addr} !== {ers1[i], erd[i]}) begin
          failures++; $display("FAIL dir_regs_%0h got rs1=%0d rd=%0d exp rs1=%0d rd=%0d",
                               ins[i], bus.rs1_addr, bus.rd_addr, ers1[i], erd[i]);
        end
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [63:0] snap;
    drive(1'b1, 32'h0020_81B3, 6'h05, 1'b1, 1'b0);
    drive(1'b1, 32'h4020_81B3, 6'h06, 1'b0, 1'b0);
    snap = {bus.alu_op, bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.imm,
            bus.src2_imm, bus.reg_write, bus.illegal, bus.pc_out};
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.alu_op, bus.pc_out} !== {1'b1, 1'b0, 6'd0, 6'h05}) begin
      failures++; $display("FAIL stall_load got v=%0b rdy=%0b op=%0d pc=%0h exp v=1 rdy=0 op=0 pc=5",
                           bus.out_valid, bus.in_ready, bus.alu_op, bus.pc_out);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h4020_81B3, 6'h06, 1'b0, c == 2);
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10 ||
          {bus.alu_op, bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.imm,
           bus.src2_imm, bus.reg_write, bus.illegal, bus.pc_out} !== snap) begin
        failures++; $display("FAIL stall_hold_%0d got v=%0b rdy=%0b op=%0d pc=%0h exp v=1 rdy=0 op=0 pc=5",
                             c, bus.out_valid, bus.in_ready, bus.alu_op, bus.pc_out);
      end
    end
    drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++; $display("FAIL flush_stall got v=%0b rdy=%0b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_dropped got=%0b exp=0", bus.out_valid);
    end
    drive(1'b1, 32'hFFF0_0093, 6'h07, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 6'h0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_input_drop got=%0b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'hFFF0_0093, 6'h09, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.alu_op} !== {1'b1, 6'd10}) begin
      failures++; $display("FAIL areset_pre got v=%0b op=%0d exp v=1 op=10", bus.out_valid, bus.alu_op);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.alu_op, bus.imm} !== '0) begin
      failures++; $display("FAIL areset_clear got v=%0b op=%0d imm=%0h exp all 0",
                           bus.out_valid, bus.alu_op, bus.imm);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic        m_valid = 1'b0;
    exp_t        m;
    logic        v, ordy, fl;
    logic [31:0] ins;
    logic [5:0]  pc;
    int unsigned kind;
    m = ref_decode(32'h0, 6'h0);
    for (int n = 0; n < 400; n++) begin
      ins  = $urandom;
      kind = $urandom_range(0, 5);
      case (kind)
        0:       ins[6:0] = 7'h33;
        1, 2:    ins[6:0] = 7'h13;
        3:       ins[6:0] = 7'h37;
        4:       ins[6:0] = 7'h17;
        default: ;
      endcase
      kind = $urandom_range(0, 2);
      if (kind == 0) ins[31:25] = 7'h00;
      else if (kind == 1) ins[31:25] = 7'h20;
      pc   = 6'($urandom);
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 19) == 0);
      drive(v, ins, pc, ordy, fl);
      checks++;
      if (bus.out_valid !== m_valid) begin
        failures++; $display("FAIL rnd_valid_%0d got=%0b exp=%0b", n, bus.out_valid, m_valid);
      end
      checks++;
      if (bus.in_ready !== (!m_valid || ordy)) begin
        failures++; $display("FAIL rnd_ready_%0d got=%0b exp=%0b", n, bus.in_ready, !m_valid || ordy);
      end
      if (m_valid) begin
        checks++;
        if ({bus.alu_op, bus.imm, bus.src2_imm, bus.reg_write, bus.illegal, bus.pc_out} !==
            {m.op, m.imm, m.s2, m.rw, m.ill, m.pc}) begin
          failures++; $display("FAIL rnd_fields_%0d got op=%0d imm=%0h s2=%0b rw=%0b ill=%0b pc=%0h exp op=%0d imm=%0h s2=%0b rw=%0b ill=%0b pc=%0h",
                               n, bus.alu_op, bus.imm, bus.src2_imm, bus.reg_write, bus.illegal, bus.pc_out,
                               m.op, m.imm, m.s2, m.rw, m.ill, m.pc);
        end
        if (!m.ill) begin
          checks++;
          if ({bus.rs1_addr, bus.rs2_addr, bus.rd_addr} !== {m.rs1, m.rs2, m.rd}) begin
            failures++; $display("FAIL rnd_regs_%0d got %0d/%0d/%0d exp %0d/%0d/%0d", n,
                                 bus.rs1_addr, bus.rs2_addr, bus.rd_addr, m.rs1, m.rs2, m.rd);
          end
        end
      end
      if (fl) m_valid = 1'b0;
      else if (v && (!m_valid || ordy)) begin
        m_valid = 1'b1;
        m       = ref_decode(ins, pc);
      end else if (ordy) m_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_directed();
    test_stall_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
